// File: rtl/fox_packet_encoder.sv
// rtl/fox_packet_encoder.sv - field staging registers feeding a first-word-fall-through packet queue
module fox_packet_encoder #(
  parameter int COORD_BITS           = 1,
  parameter int MULTICAST_GROUP_BITS = 1,
  parameter int MATRIX_TYPE_BITS     = 1,
  parameter int MATRIX_COORD_BITS    = 8,
  parameter int MATRIX_ELEMENT_BITS  = 32,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [COORD_BITS-1:0]                x_coord_in,
  input  logic                                 x_coord_in_valid,
  input  logic [COORD_BITS-1:0]                y_coord_in,
  input  logic                                 y_coord_in_valid,
  input  logic [MULTICAST_GROUP_BITS-1:0]      multicast_group_in,
  input  logic                                 multicast_group_in_valid,
  input  logic                                 ready_flag_in,
  input  logic                                 ready_flag_in_valid,
  input  logic                                 result_flag_in,
  input  logic                                 result_flag_in_valid,
  input  logic [MATRIX_TYPE_BITS-1:0]          matrix_type_in,
  input  logic                                 matrix_type_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]         matrix_x_coord_in,
  input  logic                                 matrix_x_coord_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]         matrix_y_coord_in,
  input  logic                                 matrix_y_coord_in_valid,
  input  logic [MATRIX_ELEMENT_BITS-1:0]       matrix_element_in,
  input  logic                                 matrix_element_in_valid,
  input  logic                                 packet_complete_in,
  output logic                                 message_out_ready,
  output logic [2*COORD_BITS+MULTICAST_GROUP_BITS+2+MATRIX_TYPE_BITS+2*MATRIX_COORD_BITS+MATRIX_ELEMENT_BITS-1:0] packet_out,
  output logic                                 packet_out_valid,
  input  logic                                 packet_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
  output logic [15:0]                          overflow_count
);

  localparam int PACKET_BITS = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 + MATRIX_TYPE_BITS
                             + 2*MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS;
  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(FIFO_DEPTH);

  // staging registers
  logic [COORD_BITS-1:0]           x_reg, y_reg;
  logic [MULTICAST_GROUP_BITS-1:0] mg_reg;
  logic                            ready_flag_reg, result_flag_reg;
  logic [MATRIX_TYPE_BITS-1:0]     type_reg;
  logic [MATRIX_COORD_BITS-1:0]    mx_reg, my_reg;
  logic [MATRIX_ELEMENT_BITS-1:0]  elem_reg;

  // field values as seen by a commit this cycle (same-cycle writes bypass the register)
  logic [COORD_BITS-1:0]           x_next, y_next;
  logic [MULTICAST_GROUP_BITS-1:0] mg_next;
  logic                            ready_flag_next, result_flag_next;
  logic [MATRIX_TYPE_BITS-1:0]     type_next;
  logic [MATRIX_COORD_BITS-1:0]    mx_next, my_next;
  logic [MATRIX_ELEMENT_BITS-1:0]  elem_next;
  logic [PACKET_BITS-1:0]          packet_in;

  // queue state
  logic [PACKET_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]    wr_ptr, rd_ptr;
  logic                   fifo_empty, fifo_full;
  logic                   pop, push_accept, drop;

  assign x_next           = x_coord_in_valid         ? x_coord_in         : x_reg;
  assign y_next           = y_coord_in_valid         ? y_coord_in         : y_reg;
  assign mg_next          = multicast_group_in_valid ? multicast_group_in : mg_reg;
  assign ready_flag_next  = ready_flag_in_valid      ? ready_flag_in      : ready_flag_reg;
  assign result_flag_next = result_flag_in_valid     ? result_flag_in     : result_flag_reg;
  assign type_next        = matrix_type_in_valid     ? matrix_type_in     : type_reg;
  assign mx_next          = matrix_x_coord_in_valid  ? matrix_x_coord_in  : mx_reg;
  assign my_next          = matrix_y_coord_in_valid  ? matrix_y_coord_in  : my_reg;
  assign elem_next        = matrix_element_in_valid  ? matrix_element_in  : elem_reg;

  assign packet_in = {x_next, y_next, mg_next, ready_flag_next, result_flag_next,
                      type_next, mx_next, my_next, elem_next};

  assign fifo_empty        = (fifo_count == '0);
  assign message_out_ready = (fifo_count < DEPTH_CNT);
  assign fifo_full         = !message_out_ready;
  assign packet_out_valid  = !fifo_empty;
  assign packet_out        = fifo_empty ? '0 : mem[rd_ptr];

  // a full queue still accepts a push when the head leaves in the same cycle
  assign pop         = !fifo_empty && packet_out_ready;
  assign push_accept = packet_complete_in && (!fifo_full || pop);
  assign drop        = packet_complete_in && fifo_full && !pop;

  // load each staged field on its own valid pulse; values persist across commits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg           <= '0;
      y_reg           <= '0;
      mg_reg          <= '0;
      ready_flag_reg  <= 1'b0;
      result_flag_reg <= 1'b0;
      type_reg        <= '0;
      mx_reg          <= '0;
      my_reg          <= '0;
      elem_reg        <= '0;
    end else begin
      x_reg           <= x_next;
      y_reg           <= y_next;
      mg_reg          <= mg_next;
      ready_flag_reg  <= ready_flag_next;
      result_flag_reg <= result_flag_next;
      type_reg        <= type_next;
      mx_reg          <= mx_next;
      my_reg          <= my_next;
      elem_reg        <= elem_next;
    end
  end

  // queue storage; contents are qualified by fifo_count so they need no reset
  always_ff @(posedge clk) begin
    if (push_accept) mem[wr_ptr] <= packet_in;
  end

  // pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)         rd_ptr <= rd_ptr + PTR_BITS'(1);
      case ({push_accept, pop})
        2'b10:   fifo_count <= fifo_count + CNT_BITS'(1);
        2'b01:   fifo_count <= fifo_count - CNT_BITS'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // count dropped packets, holding at the maximum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_count <= '0;
    end else if (drop && (overflow_count != 16'hFFFF)) begin
      overflow_count <= overflow_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fox_packet_encoder.sv
// tb/tb_fox_packet_encoder.sv - self-checking bench for fox_packet_encoder
module tb_fox_packet_encoder;

  localparam int DEPTH = 4;
  localparam int PB    = 54;

  logic        clk = 1'b0;
  logic        reset;
  logic        x_coord_in, x_coord_in_valid;
  logic        y_coord_in, y_coord_in_valid;
  logic        multicast_group_in, multicast_group_in_valid;
  logic        ready_flag_in, ready_flag_in_valid;
  logic        result_flag_in, result_flag_in_valid;
  logic        matrix_type_in, matrix_type_in_valid;
  logic [7:0]  matrix_x_coord_in, matrix_y_coord_in;
  logic        matrix_x_coord_in_valid, matrix_y_coord_in_valid;
  logic [31:0] matrix_element_in;
  logic        matrix_element_in_valid;
  logic        packet_complete_in;
  logic        message_out_ready;
  logic [PB-1:0] packet_out;
  logic        packet_out_valid;
  logic        packet_out_ready;
  logic [2:0]  fifo_count;
  logic [15:0] overflow_count;

  always #5 clk = ~clk;

  fox_packet_encoder #(
    .COORD_BITS(1), .MULTICAST_GROUP_BITS(1), .MATRIX_TYPE_BITS(1),
    .MATRIX_COORD_BITS(8), .MATRIX_ELEMENT_BITS(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .x_coord_in(x_coord_in), .x_coord_in_valid(x_coord_in_valid),
    .y_coord_in(y_coord_in), .y_coord_in_valid(y_coord_in_valid),
    .multicast_group_in(multicast_group_in), .multicast_group_in_valid(multicast_group_in_valid),
    .ready_flag_in(ready_flag_in), .ready_flag_in_valid(ready_flag_in_valid),
    .result_flag_in(result_flag_in), .result_flag_in_valid(result_flag_in_valid),
    .matrix_type_in(matrix_type_in), .matrix_type_in_valid(matrix_type_in_valid),
    .matrix_x_coord_in(matrix_x_coord_in), .matrix_x_coord_in_valid(matrix_x_coord_in_valid),
    .matrix_y_coord_in(matrix_y_coord_in), .matrix_y_coord_in_valid(matrix_y_coord_in_valid),
    .matrix_element_in(matrix_element_in), .matrix_element_in_valid(matrix_element_in_valid),
    .packet_complete_in(packet_complete_in),
    .message_out_ready(message_out_ready),
    .packet_out(packet_out), .packet_out_valid(packet_out_valid),
    .packet_out_ready(packet_out_ready),
    .fifo_count(fifo_count), .overflow_count(overflow_count)
  );

  // vmask bits: 8 x, 7 y, 6 group, 5 ready_flag, 4 result_flag, 3 type, 2 mx, 1 my, 0 element
  typedef struct {
    logic [8:0]  vmask;
    logic        x, y, mg, rf, rs, mt;
    logic [7:0]  mx, my;
    logic [31:0] el;
    logic        complete;
    logic        ready;
    int          exp_count;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [PB-1:0] sb_q[$];
  logic m_x, m_y, m_mg, m_rf, m_rs, m_mt;
  logic [7:0]  m_mx, m_my;
  logic [31:0] m_el;
  int m_count, m_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_pulses();
    x_coord_in_valid = 0; y_coord_in_valid = 0; multicast_group_in_valid = 0;
    ready_flag_in_valid = 0; result_flag_in_valid = 0; matrix_type_in_valid = 0;
    matrix_x_coord_in_valid = 0; matrix_y_coord_in_valid = 0; matrix_element_in_valid = 0;
    packet_complete_in = 0;
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_mg = 0; m_rf = 0; m_rs = 0; m_mt = 0;
    m_mx = 0; m_my = 0; m_el = 0; m_count = 0; m_ovf = 0;
    sb_q.delete();
  endtask

  task automatic drive(input vec_t v);
    {x_coord_in_valid, y_coord_in_valid, multicast_group_in_valid, ready_flag_in_valid,
     result_flag_in_valid, matrix_type_in_valid, matrix_x_coord_in_valid,
     matrix_y_coord_in_valid, matrix_element_in_valid} = v.vmask;
    x_coord_in = v.x; y_coord_in = v.y; multicast_group_in = v.mg;
    ready_flag_in = v.rf; result_flag_in = v.rs; matrix_type_in = v.mt;
    matrix_x_coord_in = v.mx; matrix_y_coord_in = v.my; matrix_element_in = v.el;
    packet_complete_in = v.complete;
    packet_out_ready = v.ready;
  endtask

  // called with clk low: scores any pop, updates the model, crosses one edge, checks state
  task automatic tick();
    logic pop;
    logic [PB-1:0] pkt, head;
    pop = (m_count > 0) && packet_out_ready;
    check("valid_pre", packet_out_valid, m_count > 0);
    if (pop) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL pop_empty: actual pop required none at %0t", $time);
      end else begin
        head = sb_q.pop_front();
        check("pop_pkt", packet_out, head);
      end
    end
    if (x_coord_in_valid)         m_x  = x_coord_in;
    if (y_coord_in_valid)         m_y  = y_coord_in;
    if (multicast_group_in_valid) m_mg = multicast_group_in;
    if (ready_flag_in_valid)      m_rf = ready_flag_in;
    if (result_flag_in_valid)     m_rs = result_flag_in;
    if (matrix_type_in_valid)     m_mt = matrix_type_in;
    if (matrix_x_coord_in_valid)  m_mx = matrix_x_coord_in;
    if (matrix_y_coord_in_valid)  m_my = matrix_y_coord_in;
    if (matrix_element_in_valid)  m_el = matrix_element_in;
    pkt = {m_x, m_y, m_mg, m_rf, m_rs, m_mt, m_mx, m_my, m_el};
    if (packet_complete_in) begin
      if (m_count < DEPTH || pop) begin
        sb_q.push_back(pkt);
        if (!pop) m_count++;
      end else if (m_ovf < 65535) begin
        m_ovf++;
      end
    end else if (pop) begin
      m_count--;
    end
    @(posedge clk);
    #1 clear_pulses();
    @(negedge clk);
    check("fifo_count", fifo_count, m_count);
    check("valid", packet_out_valid, m_count > 0);
    check("msg_ready", message_out_ready, m_count < DEPTH);
    check("overflow", overflow_count, m_ovf);
    if (m_count == 0) check("empty_zero", packet_out, '0);
  endtask

  task automatic commit_el(input logic [31:0] el, input logic rdy);
    vec_t v;
    v = '{vmask: 9'b000000001, x: 0, y: 0, mg: 0, rf: 0, rs: 0, mt: 0,
          mx: 0, my: 0, el: el, complete: 1, ready: rdy, exp_count: 0};
    drive(v);
    tick();
  endtask

  task automatic idle(input logic rdy);
    clear_pulses();
    packet_out_ready = rdy;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    logic [PB-1:0] exp22, a_pkt, b_pkt;

    tbl[0] = '{9'h1FF, 1, 1, 1, 1, 0, 1, 8'hA5, 8'h5A, 32'h1234_5678, 1, 0, 1};
    tbl[1] = '{9'h001, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 32'hCAFE_F00D, 1, 0, 2};
    tbl[2] = '{9'h000, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 32'h0,         1, 1, 2};
    tbl[3] = '{9'h006, 0, 0, 0, 0, 0, 0, 8'h11, 8'h22, 32'h0,         0, 1, 1};
    tbl[4] = '{9'h140, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 32'h0,         1, 1, 1};
    tbl[5] = '{9'h000, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 32'h0,         0, 1, 0};
    tbl[6] = '{9'h038, 0, 0, 0, 0, 1, 1, 8'h00, 8'h00, 32'h0,         1, 0, 1};
    tbl[7] = '{9'h000, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 32'h0,         0, 1, 0};

    x_coord_in = 0; y_coord_in = 0; multicast_group_in = 0; ready_flag_in = 0;
    result_flag_in = 0; matrix_type_in = 0; matrix_x_coord_in = 0;
    matrix_y_coord_in = 0; matrix_element_in = 0;
    clear_pulses();
    packet_out_ready = 0;
    model_reset();

    // reset state
    reset = 1;
    repeat (2) @(negedge clk);
    check("rst_valid", packet_out_valid, 0);
    check("rst_pkt", packet_out, '0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow_count, 0);
    check("rst_msg_ready", message_out_ready, 1);
    reset = 0;
    @(negedge clk);

    // single packet with explicit field packing, ready held high
    drive('{9'b110000101, 1, 0, 0, 0, 0, 0, 8'd3, 8'd0, 32'hDEAD_BEEF, 1, 1, 0});
    tick();
    exp22 = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h00, 32'hDEAD_BEEF};
    check("pack_valid", packet_out_valid, 1);
    check("pack_fields", packet_out, exp22);
    idle(1);
    check("pack_gone", packet_out_valid, 0);

    // fill, overflow, then drain in order
    for (int i = 0; i < 4; i++) commit_el(32'h100 + i, 0);
    check("full_count", fifo_count, 4);
    check("full_msg_ready", message_out_ready, 0);
    commit_el(32'h1FF, 0);
    check("ovf_one", overflow_count, 1);
    idle(0);
    check("hold_stable", packet_out[31:0], 32'h100);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", packet_out[31:0], 32'h100 + i);
      idle(1);
    end

    // full queue with simultaneous push and pop
    for (int i = 0; i < 4; i++) commit_el(32'h200 + i, 0);
    commit_el(32'h2FF, 1);
    check("pp_count", fifo_count, 4);
    check("pp_ovf", overflow_count, 1);
    for (int i = 0; i < 4; i++) begin
      check("pp_order", packet_out[31:0], (i == 3) ? 32'h2FF : 32'h201 + i);
      idle(1);
    end

    // carry-over: only the element differs between consecutive packets
    commit_el(32'hA, 0);
    commit_el(32'hB, 0);
    a_pkt = packet_out;
    idle(1);
    b_pkt = packet_out;
    check("carry_upper", b_pkt[PB-1:32], a_pkt[PB-1:32]);
    check("carry_a_el", a_pkt[31:0], 32'hA);
    check("carry_b_el", b_pkt[31:0], 32'hB);
    idle(1);

    // same-cycle element write is included in the committed packet
    commit_el(32'h5, 0);
    check("bypass_el", packet_out[31:0], 32'h5);
    idle(1);

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i]);
      tick();
      check("tbl_count", fifo_count, tbl[i].exp_count);
    end

    // asynchronous reset with packets queued
    for (int i = 0; i < 3; i++) commit_el(32'h300 + i, 0);
    check("pre_rst_count", fifo_count, 3);
    #2 reset = 1;
    #1;
    check("arst_valid", packet_out_valid, 0);
    check("arst_count", fifo_count, 0);
    check("arst_msg_ready", message_out_ready, 1);
    check("arst_ovf", overflow_count, 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    commit_el(32'h400, 0);
    check("post_rst_count", fifo_count, 1);
    check("post_rst_pkt", packet_out, {22'h0, 32'h400});
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
